// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared types and helpers for the dual-port RAM responder.
//                Read latency follows RAM_DP_OUT_REG_EN (defined -> 2 cycles).
//  Revision    : 1.0
// ============================================================================
package ram_pkg;

    typedef enum logic [0:0] {
        RAM_CLEAR = 1'b0,
        RAM_READY = 1'b1
    } ram_state_t;

`ifdef RAM_DP_OUT_REG_EN
    localparam int RAM_READ_LAT = 2;
`else
    localparam int RAM_READ_LAT = 1;
`endif

    // The comparison is made on the full address, before any truncation to an index.
    function automatic logic ram_in_range(input logic [63:0] addr, input logic [63:0] depth);
        return addr < depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_if
//  Description : Two-port byte RAM bus; m = requester, s = responder.
//  Revision    : 1.0
// ============================================================================
interface ram_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) ();

    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [BYTE_WIDTH-1:0] write_a;
    logic [BYTE_WIDTH-1:0] write_b;
    logic                  write_en_a;
    logic                  write_en_b;
    logic [BYTE_WIDTH-1:0] data_a;
    logic [BYTE_WIDTH-1:0] data_b;

    modport m (
        output addr_a, addr_b, write_a, write_b, write_en_a, write_en_b,
        input  data_a, data_b
    );

    modport s (
        input  addr_a, addr_b, write_a, write_b, write_en_a, write_en_b,
        output data_a, data_b
    );

endinterface
`default_nettype wire

// File: rtl/ram_dp_core.sv
`default_nettype none
// ============================================================================
//  Module      : ram_dp_core
//  Description : Bare two-port storage array, read-first, registered reads,
//                port A wins a same-address write collision.
//  Revision    : 1.0
// ============================================================================
module ram_dp_core #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we_a,
    input  logic [IDX_W-1:0] i_idx_a,
    input  logic [WIDTH-1:0] i_wdata_a,
    input  logic             i_we_b,
    input  logic [IDX_W-1:0] i_idx_b,
    input  logic [WIDTH-1:0] i_wdata_b,
    output logic [WIDTH-1:0] o_rdata_a,
    output logic [WIDTH-1:0] o_rdata_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_we_b;

    assign w_we_b = i_we_b && !(i_we_a && (i_idx_a == i_idx_b));

    // Reads sample the array before this edge's writes land (read-first on both ports).
    always_ff @(posedge clk) begin
        if (i_we_a) begin
            r_mem[i_idx_a] <= i_wdata_a;
        end
        if (w_we_b) begin
            r_mem[i_idx_b] <= i_wdata_b;
        end
        o_rdata_a <= r_mem[i_idx_a];
        o_rdata_b <= r_mem[i_idx_b];
    end

endmodule
`default_nettype wire

// File: rtl/ram_dp_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ram_dp_responder
//  Description : ram_if responder with self-clearing dual-port byte RAM.
//                RAM_DP_OUT_REG_EN adds an output register (read latency 2).
//  Revision    : 1.0
// ============================================================================
module ram_dp_responder
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic aclk,
    input  logic aresetn,
    ram_if.s     ram,
    output logic init_done
);

    localparam int                 c_idx_w    = $clog2(MEM_DEPTH);
    localparam logic [c_idx_w-1:0] c_last_ptr = c_idx_w'(MEM_DEPTH - 2);

    ram_state_t             r_state;
    ram_state_t             w_state_nxt;
    logic [c_idx_w-1:0]     r_ptr;
    logic [c_idx_w-1:0]     w_ptr_nxt;

    logic [ADDR_WIDTH-1:0]  w_addr_a;
    logic [ADDR_WIDTH-1:0]  w_addr_b;
    logic                   w_inr_a;
    logic                   w_inr_b;

    logic                   w_we_a;
    logic                   w_we_b;
    logic [c_idx_w-1:0]     w_idx_a;
    logic [c_idx_w-1:0]     w_idx_b;
    logic [BYTE_WIDTH-1:0]  w_wdata_a;
    logic [BYTE_WIDTH-1:0]  w_wdata_b;
    logic [BYTE_WIDTH-1:0]  w_core_rdata_a;
    logic [BYTE_WIDTH-1:0]  w_core_rdata_b;

    logic                   r_rd_ok_a;
    logic                   r_rd_ok_b;
    logic [BYTE_WIDTH-1:0]  w_data_a;
    logic [BYTE_WIDTH-1:0]  w_data_b;

    assign w_addr_a  = ram.addr_a;
    assign w_addr_b  = ram.addr_b;
    assign w_inr_a   = ram_in_range(64'(w_addr_a), 64'(MEM_DEPTH));
    assign w_inr_b   = ram_in_range(64'(w_addr_b), 64'(MEM_DEPTH));
    assign init_done = (r_state == RAM_READY);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= RAM_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // While clearing, the walker owns both core ports and bus writes are ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_we_a      = 1'b0;
        w_we_b      = 1'b0;
        w_idx_a     = w_addr_a[c_idx_w-1:0];
        w_idx_b     = w_addr_b[c_idx_w-1:0];
        w_wdata_a   = ram.write_a;
        w_wdata_b   = ram.write_b;
        case (r_state)
            RAM_CLEAR: begin
                w_we_a    = 1'b1;
                w_we_b    = 1'b1;
                w_idx_a   = r_ptr;
                w_idx_b   = r_ptr + c_idx_w'(1);
                w_wdata_a = '0;
                w_wdata_b = '0;
                w_ptr_nxt = r_ptr + c_idx_w'(2);
                if (r_ptr == c_last_ptr) begin
                    w_state_nxt = RAM_READY;
                end
            end
            RAM_READY: begin
                w_we_a = ram.write_en_a && w_inr_a;
                w_we_b = ram.write_en_b && w_inr_b;
            end
            default: begin
                w_state_nxt = RAM_CLEAR;
            end
        endcase
    end

    ram_dp_core #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (BYTE_WIDTH),
        .IDX_W (c_idx_w)
    ) u_core (
        .clk       (aclk),
        .i_we_a    (w_we_a),
        .i_idx_a   (w_idx_a),
        .i_wdata_a (w_wdata_a),
        .i_we_b    (w_we_b),
        .i_idx_b   (w_idx_b),
        .i_wdata_b (w_wdata_b),
        .o_rdata_a (w_core_rdata_a),
        .o_rdata_b (w_core_rdata_b)
    );

    // Qualifier tracks the core's read register so reset, clear and out-of-range all read as zero.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rd_ok_a <= 1'b0;
            r_rd_ok_b <= 1'b0;
        end else begin
            r_rd_ok_a <= (r_state == RAM_READY) && w_inr_a;
            r_rd_ok_b <= (r_state == RAM_READY) && w_inr_b;
        end
    end

    assign w_data_a = r_rd_ok_a ? w_core_rdata_a : '0;
    assign w_data_b = r_rd_ok_b ? w_core_rdata_b : '0;

    generate
        if (RAM_READ_LAT == 2) begin : g_out_reg
            logic [BYTE_WIDTH-1:0] r_data_a;
            logic [BYTE_WIDTH-1:0] r_data_b;

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    r_data_a <= '0;
                    r_data_b <= '0;
                end else begin
                    r_data_a <= w_data_a;
                    r_data_b <= w_data_b;
                end
            end

            assign ram.data_a = r_data_a;
            assign ram.data_b = r_data_b;
        end else begin : g_no_out_reg
            assign ram.data_a = w_data_a;
            assign ram.data_b = w_data_b;
        end
    endgenerate

endmodule
`default_nettype wire
